// File: rtl/scan_sel_sequencer.sv
// ---------------------------------------------------------------------------
// scan_sel_sequencer
//
// Purpose:
//   Upstream stage for a 3-to-8 one-hot decoder. It produces the channel
//   index the decoder expands. A scan walks the enabled channels in ascending
//   order and holds each one for dwell+1 cycles. Scans can run once
//   (single pass, ending with a done pulse) or wrap continuously until stop.
//   There are no gap cycles between channels. The next channel is found by a
//   single-cycle combinational priority search.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   start      in   begin a scan (sampled only while idle)
//   stop       in   abort the scan (wins over start and over an advance)
//   mode_cont  in   1 = continuous wrap, 0 = single pass (latched at start)
//   ch_mask    in   channel enables, bit i = channel i (latched at start)
//   dwell      in   each channel is held dwell+1 cycles (latched at start)
//   sel        out  current channel index, feeds the decoder
//   sel_valid  out  sel is a live selection
//   sel_new    out  1-cycle pulse in the first cycle a channel is shown
//   busy       out  scan in progress
//   done       out  1-cycle pulse when a single pass completes
// ---------------------------------------------------------------------------
module scan_sel_sequencer #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode_cont,
  input  logic [2**SEL_W-1:0]   ch_mask,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [SEL_W-1:0]      sel,
  output logic                  sel_valid,
  output logic                  sel_new,
  output logic                  busy,
  output logic                  done
);

  localparam int N_CH = 2**SEL_W;

  typedef enum logic {
    S_IDLE,
    S_DWELL
  } state_t;

  state_t              r_state;
  logic [N_CH-1:0]     r_mask;
  logic                r_cont;
  logic [DWELL_W-1:0]  r_dwell;
  logic [DWELL_W-1:0]  r_cnt;

  logic                w_next_found;
  logic [SEL_W-1:0]    w_next_idx;
  logic [SEL_W-1:0]    w_first_idx;
  logic [SEL_W-1:0]    w_wrap_idx;
  logic                w_start_ok;

  // Index of the lowest set bit; callers guarantee the mask is non-zero.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [N_CH-1:0] m);
    lowest_set = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = SEL_W'(i);
    end
  endfunction

  // Next enabled channel strictly above the current one.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is
    // inferred when the search finds nothing.
    w_next_found = 1'b0;
    w_next_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_mask[i] && (i > int'(sel))) begin
        w_next_found = 1'b1;
        w_next_idx   = SEL_W'(i);
      end
    end
  end

  assign w_first_idx = lowest_set(ch_mask);
  assign w_wrap_idx  = lowest_set(r_mask);
  assign w_start_ok  = start && !stop && (ch_mask != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register updates from pre-edge values, independent of statement order.
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_cont    <= 1'b0;
      r_dwell   <= '0;
      r_cnt     <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      sel_new   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Both pulses default low and are raised only for their one cycle.
      sel_new <= 1'b0;
      done    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_state   <= S_DWELL;
            r_mask    <= ch_mask;
            r_cont    <= mode_cont;
            r_dwell   <= dwell;
            r_cnt     <= dwell;
            sel       <= w_first_idx;
            sel_valid <= 1'b1;
            sel_new   <= 1'b1;
            busy      <= 1'b1;
          end
        end

        S_DWELL: begin
          if (stop) begin
            // Abort: all outputs return to idle values, no done pulse.
            r_state   <= S_IDLE;
            sel       <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - DWELL_W'(1);
          end else if (w_next_found) begin
            sel     <= w_next_idx;
            sel_new <= 1'b1;
            r_cnt   <= r_dwell;
          end else if (r_cont) begin
            // Wrap; a single-bit mask re-presents the same channel.
            sel     <= w_wrap_idx;
            sel_new <= 1'b1;
            r_cnt   <= r_dwell;
          end else begin
            // Single pass exhausted: done coincides with sel_valid falling.
            r_state   <= S_IDLE;
            sel       <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sel_sequencer.sv
// ---------------------------------------------------------------------------
// tb_scan_sel_sequencer
//
// Self-checking bench for scan_sel_sequencer. A scan model computes the
// expected outputs from the time elapsed since start: the position in the
// enabled-channel list is t / (dwell+1), a new channel appears whenever
// t % (dwell+1) == 0, and a single pass ends at position k. A compare
// process checks every cycle; directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_scan_sel_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       mode_cont;
  logic [7:0] ch_mask;
  logic [7:0] dwell;
  logic [2:0] sel;
  logic       sel_valid;
  logic       sel_new;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  scan_sel_sequencer #(.SEL_W(3), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode_cont (mode_cont),
    .ch_mask   (ch_mask),
    .dwell     (dwell),
    .sel       (sel),
    .sel_valid (sel_valid),
    .sel_new   (sel_new),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scan model ----------------
  bit m_active;
  bit m_cont;
  int m_list[8];
  int m_k;
  int m_len;
  int m_t;
  int e_sel;
  bit e_valid, e_new, e_busy, e_done;

  task automatic m_idle_outputs();
    e_sel   = 0;
    e_valid = 1'b0;
    e_new   = 1'b0;
    e_busy  = 1'b0;
  endtask

  always @(posedge clk) begin
    e_done = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_idle_outputs();
    end else if (m_active) begin
      if (stop) begin
        m_active = 1'b0;
        m_idle_outputs();
      end else begin
        int pos;
        m_t++;
        pos = m_t / m_len;
        if (m_cont || pos < m_k) begin
          e_sel   = m_list[pos % m_k];
          e_new   = (m_t % m_len) == 0;
          e_valid = 1'b1;
          e_busy  = 1'b1;
        end else begin
          m_active = 1'b0;
          m_idle_outputs();
          e_done = 1'b1;
        end
      end
    end else begin
      m_idle_outputs();
      if (start && !stop && ch_mask != 8'h00) begin
        m_k = 0;
        for (int i = 0; i < 8; i++) begin
          if (ch_mask[i]) begin
            m_list[m_k] = i;
            m_k++;
          end
        end
        m_len    = int'(dwell) + 1;
        m_cont   = mode_cont;
        m_t      = 0;
        m_active = 1'b1;
        e_sel    = m_list[0];
        e_valid  = 1'b1;
        e_new    = 1'b1;
        e_busy   = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_sel",       int'(sel),       e_sel);
      check("m_sel_valid", int'(sel_valid), int'(e_valid));
      check("m_sel_new",   int'(sel_new),   int'(e_new));
      check("m_busy",      int'(busy),      int'(e_busy));
      check("m_done",      int'(done),      int'(e_done));
      check("inv_done_new_excl", int'(done & sel_new), 0);
      if (!sel_valid) check("inv_sel_zero_when_invalid", int'(sel), 0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Scenario 2 (optionally with mid-scan perturbations of scenario 5).
  task automatic run_sparse(input bit perturb);
    int exp_sel[9] = '{2, 2, 2, 5, 5, 5, 7, 7, 7};
    ch_mask   = 8'b1010_0100;
    dwell     = 8'd2;
    mode_cont = 1'b0;
    start     = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      start = 1'b0;
      check("s2_sel", int'(sel), exp_sel[c-1]);
      check("s2_sel_new", int'(sel_new), (c == 1 || c == 4 || c == 7) ? 1 : 0);
      check("s2_busy", int'(busy), 1);
      if (perturb && c == 2) begin
        ch_mask   = 8'h01;
        dwell     = 8'd0;
        mode_cont = 1'b1;
      end
      if (perturb && c == 3) start = 1'b1;
    end
    step();
    check("s2_done", int'(done), 1);
    check("s2_valid_fall", int'(sel_valid), 0);
    step();
    check("s2_done_one_cycle", int'(done), 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    mode_cont = 1'b0;
    ch_mask   = 8'h00;
    dwell     = 8'd0;
    step();
    step();
    cmp_en = 1'b1;
    check("rst_sel", int'(sel), 0);
    check("rst_valid", int'(sel_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sel_new", int'(sel_new), 0);
    rst = 1'b0;
    step();

    // 1. Full single pass, dwell 0.
    ch_mask = 8'hFF;
    dwell   = 8'd0;
    start   = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      start = 1'b0;
      check("s1_sel", int'(sel), c - 1);
      check("s1_sel_new", int'(sel_new), 1);
      check("s1_valid", int'(sel_valid), 1);
    end
    step();
    check("s1_done", int'(done), 1);
    check("s1_valid_fall", int'(sel_valid), 0);
    check("s1_busy_fall", int'(busy), 0);
    step();
    check("s1_done_one_cycle", int'(done), 0);
    idle_cycles(2);

    // 2. Sparse single pass with dwell 2.
    run_sparse(1'b0);
    idle_cycles(2);

    // 3. Continuous two-channel scan, then stop.
    begin
      int exp_sel[7] = '{0, 0, 7, 7, 0, 0, 7};
      ch_mask   = 8'h81;
      dwell     = 8'd1;
      mode_cont = 1'b1;
      start     = 1'b1;
      for (int c = 1; c <= 7; c++) begin
        step();
        start = 1'b0;
        check("s3_sel", int'(sel), exp_sel[c-1]);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("s3_stop_valid", int'(sel_valid), 0);
      check("s3_stop_busy", int'(busy), 0);
      check("s3_stop_done", int'(done), 0);
      check("s3_stop_sel", int'(sel), 0);
    end
    idle_cycles(2);

    // 4. Single-channel continuous: same channel re-presented every cycle.
    ch_mask   = 8'h10;
    dwell     = 8'd0;
    mode_cont = 1'b1;
    start     = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      start = 1'b0;
      check("s4_sel", int'(sel), 4);
      check("s4_sel_new", int'(sel_new), 1);
      check("s4_done", int'(done), 0);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    mode_cont = 1'b0;
    idle_cycles(2);

    // 5a. Start with an empty mask is ignored.
    ch_mask = 8'h00;
    start   = 1'b1;
    step();
    start = 1'b0;
    check("s5_empty_valid", int'(sel_valid), 0);
    check("s5_empty_busy", int'(busy), 0);
    step();
    check("s5_empty_done", int'(done), 0);

    // 5b. Start and stop together while idle: stop wins.
    ch_mask = 8'hFF;
    start   = 1'b1;
    stop    = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("s5_startstop_busy", int'(busy), 0);
    check("s5_startstop_valid", int'(sel_valid), 0);
    idle_cycles(2);

    // 5c. Scenario 2 with mask/dwell/mode changes and a second start mid-scan.
    run_sparse(1'b1);
    mode_cont = 1'b0;
    idle_cycles(2);

    // 6. Reset mid-scan with start also high, then a fresh scan.
    ch_mask = 8'hFF;
    dwell   = 8'd0;
    start   = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      start = 1'b0;
    end
    check("s6_pre_rst_sel", int'(sel), 4);
    rst   = 1'b1;
    start = 1'b1;
    step();
    check("s6_rst_sel", int'(sel), 0);
    check("s6_rst_valid", int'(sel_valid), 0);
    check("s6_rst_busy", int'(busy), 0);
    check("s6_rst_done", int'(done), 0);
    rst   = 1'b0;
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("s6_restart_sel", int'(sel), 0);
    check("s6_restart_valid", int'(sel_valid), 1);
    check("s6_restart_new", int'(sel_new), 1);
    step();
    check("s6_restart_next", int'(sel), 1);
    idle_cycles(10);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_sel_sequencer.md
Name: scan_sel_sequencer

Overview:
- Upstream stage for the 3-to-8 one-hot decoder.
- Generates the 3-bit channel index that the decoder expands. It walks the enabled channels in ascending order and holds each one for a programmable dwell time.
- Supports single-pass and continuous scan, abort, and a done pulse.
- Output `sel` drives the decoder input directly. `sel_valid` gates the decoder output downstream.

Parameters:
- SEL_W, 3, index width; channel count N_CH = 2**SEL_W.
- DWELL_W, 8, width of the dwell count.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a scan; sampled only in IDLE.
- stop  input  1  abort the scan; synchronous.
- mode_cont  input  1  1 = continuous wrap, 0 = single pass; latched at start.
- ch_mask  input  N_CH  channel enable, bit i = channel i; latched at start.
- dwell  input  DWELL_W  hold each channel for dwell+1 cycles; latched at start.
- sel  output  SEL_W  current channel index, feeds the decoder.
- sel_valid  output  1  sel is a live selection.
- sel_new  output  1  1-cycle pulse in the first cycle a channel is presented.
- busy  output  1  scan in progress.
- done  output  1  1-cycle pulse at single-pass completion.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; latched mask, mode and dwell cleared.
- All outputs are registered.

States:
- IDLE
  - Outputs: sel=0, sel_valid=0, busy=0.
  - start=1, stop=0, ch_mask!=0: latch mask, mode and dwell; go to DWELL.
  - First-channel timing: in cycle T+1, sel = lowest set bit of the mask, sel_valid=1, sel_new=1, busy=1; dwell counter loaded with dwell.
  - start with ch_mask==0: ignored; stay IDLE; no done.
  - start and stop in the same cycle: stop wins; stay IDLE.
- DWELL
  - Counter != 0: decrement; sel held.
  - Counter == 0: advance.
    - Next channel = lowest set latched-mask bit strictly above sel. Found in a single-cycle combinational priority search; there is no seek state.
    - If found: load it; sel_new=1; reload counter.
    - If none found and mode continuous: wrap to lowest set bit. A single-bit mask re-presents the same channel with sel_new=1.
    - If none found and mode single: go to IDLE; next cycle sel_valid=0, busy=0, sel=0, done=1 for exactly 1 cycle.

Timing and arithmetic:
- Each channel is visible for exactly dwell+1 cycles; no gap cycles between channels.
- Single-pass duration for k enabled channels: k*(dwell+1) cycles of sel_valid.
- done is asserted in the cycle sel_valid first falls.
- Dwell counter is DWELL_W bits and counts down; it never wraps below 0.

Boundary conditions:
- stop in DWELL: next cycle IDLE, all outputs 0, done stays 0; takes priority over a simultaneous advance.
- start while busy: ignored.
- ch_mask, dwell and mode_cont changes during a scan: ignored until the next start.
- rst mid-scan: next cycle is the reset state regardless of start/stop.
- done and sel_new are never both 1.
- sel_valid=0 implies sel=0.

Test Plan:
1. Full single pass
   - Stimulus: ch_mask=8'hFF, dwell=0, mode_cont=0, start pulse at T.
   - Required: sel=0..7 on cycles T+1..T+8, sel_new=1 every cycle; done=1 and sel_valid=0 at T+9; busy low from T+9.
2. Sparse single pass with dwell
   - Stimulus: ch_mask=8'b1010_0100, dwell=2, start pulse at T.
   - Required: sel=2 for T+1..T+3, sel=5 for T+4..T+6, sel=7 for T+7..T+9, done at T+10.
   - Required: sel_new only at T+1, T+4, T+7.
3. Continuous scan and stop
   - Stimulus: ch_mask=8'h81, dwell=1, mode_cont=1; stop asserted at T+7.
   - Required: sel = 0,0,7,7,0,0,7 over T+1..T+7; at T+8 sel_valid=0, busy=0, done=0.
4. Single-channel continuous
   - Stimulus: ch_mask=8'h10, dwell=0, mode_cont=1.
   - Required: sel=4 every cycle; sel_new=1 every cycle; done never asserted.
5. Ignored and blocked requests
   - start with ch_mask=0: no output activity.
   - Second start at T+3 of scenario 2: ignored.
   - ch_mask changed to 8'h01 at T+2 of scenario 2: sequence unchanged.
   - start+stop together in IDLE: stays IDLE.
6. Reset mid-scan
   - Stimulus: rst=1 at T+5 of scenario 1, with start also high.
   - Required: at T+6 sel=0, sel_valid=0, busy=0, done=0.
   - Required: a fresh start after rst is released restarts from channel 0.
